// File: rtl/round_key_sequencer.sv
// Holds a captured AES key schedule and streams one 128-bit round key per
// valid/ready transfer, forward (0..nr) for encryption or reverse (nr..0) for decryption.
module round_key_sequencer #(
  parameter int nk = 4,
  parameter int nr = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   decrypt,
  input  logic [128*(nr+1)-1:0]  w,
  output logic [127:0]           rk,
  output logic [3:0]             rk_round,
  output logic                   rk_valid,
  input  logic                   rk_ready,
  output logic                   rk_last,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  localparam logic [3:0] LAST_FWD = 4'(nr);

  // nk only has to agree with the upstream expander (nr = nk + 6); nothing is sized by it.
  if (nr != nk + 6) begin : g_nk_nr_mismatch
  end

  state_t              state, next_state;
  logic [nr:0][127:0]  keys_q;
  logic                dir_q;
  logic [3:0]          idx;
  logic                at_last;
  logic                xfer;

  assign at_last = (idx == (dir_q ? 4'd0 : LAST_FWD));
  assign xfer    = (state == ISSUE) && rk_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = ISSUE;
      ISSUE:   if (xfer && at_last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // rk/rk_round come straight from the held index, so they stay put through stalls and DONE.
  always_comb begin
    rk_valid = (state == ISSUE);
    rk_last  = (state == ISSUE) && at_last;
    busy     = (state != IDLE);
    done     = (state == DONE);
    rk       = keys_q[idx];
    rk_round = idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      keys_q <= '0;
      dir_q  <= 1'b0;
      idx    <= 4'd0;
    end else if (state == IDLE && start) begin
      keys_q <= w;
      dir_q  <= decrypt;
      idx    <= decrypt ? LAST_FWD : 4'd0;
    end else if (xfer && !at_last) begin
      idx    <= dir_q ? idx - 4'd1 : idx + 4'd1;
    end
  end

endmodule

// File: tb/tb_round_key_sequencer.sv
// Directed/random bench for round_key_sequencer: expected key order comes from a
// captured copy of the schedule walked forward or backward by plain index arithmetic.
module tb_round_key_sequencer;
  localparam int NK = 4;
  localparam int NR = 10;

  logic                  clk = 1'b0;
  logic                  rst, start, decrypt, rk_ready;
  logic [128*(NR+1)-1:0] w;
  logic [127:0]          rk;
  logic [3:0]            rk_round;
  logic                  rk_valid, rk_last, busy, done;

  int checks = 0;
  int errors = 0;

  logic [127:0] fips [0:NR] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
  logic [127:0] sched [0:NR];
  logic [127:0] cap   [0:NR];

  round_key_sequencer #(.nk(NK), .nr(NR)) dut (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .w(w),
    .rk(rk), .rk_round(rk_round), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_last(rk_last), .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_k(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_n(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_sched();
    for (int k = 0; k <= NR; k++) w[128*k +: 128] = sched[k];
  endtask

  // Entered in an IDLE cycle; leaves in the IDLE cycle right after done.
  task automatic run_seq(input bit dec, input int ready_pct, input int poke_round);
    int  i, cyc, exp_r, last_r;
    bit  rdy, poked;
    drive_sched();
    for (int k = 0; k <= NR; k++) cap[k] = sched[k];
    start = 1'b1; decrypt = dec; rk_ready = 1'b0;
    step();
    start = 1'b0; decrypt = 1'($urandom_range(1));
    chk_b("first_valid", rk_valid, 1'b1);
    i = 0; cyc = 0; poked = 1'b0;
    while (i <= NR && cyc < 400) begin
      exp_r = dec ? NR - i : i;
      chk_b("rk_valid", rk_valid, 1'b1);
      chk_n("rk_round", int'(rk_round), exp_r);
      chk_k("rk", rk, cap[exp_r]);
      chk_b("rk_last", rk_last, i == NR);
      chk_b("busy_issue", busy, 1'b1);
      chk_b("done_issue", done, 1'b0);
      rdy = ($urandom_range(99) < ready_pct);
      rk_ready = rdy;
      if (exp_r == poke_round && !poked) begin
        start = 1'b1; decrypt = ~dec; poked = 1'b1;
        for (int k = 0; k < 4*(NR+1); k++) w[32*k +: 32] = $urandom;
      end
      step();
      start = 1'b0;
      if (rdy) i++;
      cyc++;
    end
    chk_b("no_timeout", i > NR, 1'b1);
    if (ready_pct >= 100) chk_n("valid_cycles", cyc, NR + 1);
    last_r = dec ? 0 : NR;
    rk_ready = 1'($urandom_range(1));
    chk_b("done_pulse", done, 1'b1);
    chk_b("busy_done", busy, 1'b1);
    chk_b("valid_done", rk_valid, 1'b0);
    chk_k("rk_hold_done", rk, cap[last_r]);
    chk_n("round_hold_done", int'(rk_round), last_r);
    step();
    chk_b("done_one_cycle", done, 1'b0);
    chk_b("busy_idle", busy, 1'b0);
    chk_b("valid_idle", rk_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; decrypt = 1'b0; rk_ready = 1'b0; w = '0;
    for (int k = 0; k <= NR; k++) sched[k] = fips[k];
    drive_sched();
    step(); step();
    chk_k("rst_rk", rk, 128'h0);
    chk_n("rst_round", int'(rk_round), 0);
    chk_b("rst_valid", rk_valid, 1'b0);
    chk_b("rst_last", rk_last, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_done", done, 1'b0);
    rst = 1'b0;
    step();
    chk_b("idle_busy", busy, 1'b0);

    // FIPS-197 schedule, forward then an immediate back-to-back reverse
    run_seq(1'b0, 100, -1);
    run_seq(1'b1, 100, -1);
    // backpressure
    run_seq(1'b0, 50, -1);
    run_seq(1'b1, 50, -1);
    // start + w change mid-sequence must be ignored
    run_seq(1'b0, 100, 4);
    run_seq(1'b1, 60, 4);

    // reset at round 5 of a forward sequence
    drive_sched();
    start = 1'b1; decrypt = 1'b0; rk_ready = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 20 && rk_round != 4'd5; c++) step();
    chk_n("at_round5", int'(rk_round), 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_b("abort_valid", rk_valid, 1'b0);
    chk_b("abort_busy", busy, 1'b0);
    chk_b("abort_done", done, 1'b0);
    chk_k("abort_rk", rk, 128'h0);
    chk_n("abort_round", int'(rk_round), 0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk_b("abort_no_done", done, 1'b0);
    end
    run_seq(1'b0, 100, -1);

    // random schedules
    for (int k = 0; k <= NR; k++) sched[k] = {$urandom, $urandom, $urandom, $urandom};
    run_seq(1'b1, 50, 7);
    run_seq(1'b0, 70, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/round_key_sequencer.md
Name: round_key_sequencer

Overview:
Sequential stage directly downstream of the Decryption_Key key-expansion block. It captures the full expanded key schedule w on a start request. It then issues one 128-bit round key per accepted transfer to an iterative AES round datapath over a valid/ready handshake. Order is forward (round 0..nr) for encryption or reverse (round nr..0) for decryption.

Parameters:
nk, 4, key length in 32-bit words (4/6/8); informational, must match the upstream key-expansion block.
nr, 10, number of AES rounds (10/12/14); schedule holds nr+1 round keys.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request to capture w and begin a sequence; honoured only in IDLE
decrypt  input  1  sampled with start: 1 = reverse order (nr..0), 0 = forward order (0..nr)
w  input  128*(nr+1)  expanded key schedule; round key k occupies bits [128*k : 128*k+127], round 0 = cipher key
rk  output  128  current round key
rk_round  output  4  index of the round key on rk
rk_valid  output  1  rk/rk_round/rk_last are valid
rk_ready  input  1  consumer accepts rk this cycle when rk_valid=1
rk_last  output  1  high with rk_valid on the final key of the sequence
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle pulse after the final key transfer

Behaviour:
- Reset (rst=1 at a clock edge, any state): state=IDLE; rk=0, rk_round=0, rk_valid=0, rk_last=0, busy=0, done=0; captured schedule register cleared to 0.
- States: IDLE, ISSUE, DONE.
- IDLE: if start=1, register w into w_q, register decrypt into dir_q, set idx = dir_q ? nr : 0, go to ISSUE. Otherwise hold.
- Latency: start sampled at edge T gives rk_valid=1 with the first key after edge T (visible in cycle T+1).
- ISSUE: rk_valid=1; rk = w_q[128*idx +: 128]; rk_round=idx; rk_last=1 iff idx == (dir_q ? 0 : nr).
- Transfer occurs on an edge where rk_valid & rk_ready.
  - Non-final key: idx steps +1 (forward) or -1 (reverse); next key is presented the following cycle with no bubble.
  - Final key: go to DONE, rk_valid drops.
- Stall: while rk_valid=1 and rk_ready=0, rk, rk_round and rk_last hold stable. rk_ready is ignored when rk_valid=0.
- DONE: done=1 for exactly one cycle, busy=1, rk_valid=0, then unconditionally return to IDLE. rk and rk_round retain the last issued values.
- start while busy (ISSUE or DONE) is ignored; changes on w after capture have no effect until the next accepted start.
- Back-to-back: start asserted in the cycle after done (state IDLE) is accepted normally. Minimum gap between sequences is one IDLE cycle.
- idx is 4 bits, never leaves 0..nr; no wrap-around. Forward stops after nr, reverse stops after 0.
- rst asserted mid-sequence aborts immediately: next cycle rk_valid=0, no done pulse.
- Sequence length is always nr+1 transfers.

Test Plan:
- Forward, rk_ready tied 1: w = FIPS-197 AES-128 schedule for key 2b7e151628aed2a6abf7158809cf4f3c, decrypt=0, start pulse. Expect 11 consecutive valid cycles. rk_round 0 gives 2b7e1516...09cf4f3c; round 1 gives a0fafe1788542cb123a339392a6c7605; round 10 gives d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1. done pulses the next cycle; busy falls after it.
- Reverse, same schedule, decrypt=1: first key is d014f9a8...0ca6 with rk_round=10; rk_round then decrements to 0. The last key is 2b7e1516...09cf4f3c with rk_last=1. Then done=1.
- Backpressure: random rk_ready (roughly 50% duty). Expect rk/rk_round stable during every stall, exactly 11 transfers in correct order, and no duplicates or skips.
- start during busy, plus w change after capture: assert start and alter w at round 4. Expect the sequence to continue unaffected, with no restart and the original keys emitted.
- Reset mid-operation: assert rst at round 5 of a forward sequence. Next cycle expect rk_valid=0, busy=0, done never pulses, and rk=0. A new start then begins again at round 0.
- Back-to-back: a forward sequence, then a decrypt start one cycle after done. Expect the second sequence to begin with rk_round=10 and rk_valid high two cycles after done.
